pwr_seq_ctrl: RTL

//  Power-rail sequencer between the AXI register bank and the board power-enable pins.

---
 rtl/pwr_seq_ctrl_pkg.sv | 18 +
 rtl/flt_filter.sv | 38 +++
 rtl/pwr_seq_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/pwr_seq_ctrl_pkg.sv
// Shared types for the power-rail sequencer: FSM state codes and small helpers.
package pwr_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        StOff   = 3'd0,
        StUp3v3 = 3'd1,
        StUp2v5 = 3'd2,
        StUpCh  = 3'd3,
        StOn    = 3'd4,
        StDown  = 3'd5,
        StFault = 3'd6
    } seq_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/flt_filter.sv
// Fault input qualifier: 2-FF synchroniser followed by a consecutive-high counter.
module flt_filter #(
    parameter int unsigned FILT = 16
) (
    input  logic clk_axi,
    input  logic rst_axi_n,
    input  logic raw_i,
    output logic filt_o
);

    localparam int unsigned CW = $clog2(FILT + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Saturates at FILT; any synced low restarts qualification.
    always_comb begin
        cnt_d = cnt_q;
        if (!sync_q[1]) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(FILT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_axi or negedge rst_axi_n) begin
        if (!rst_axi_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], raw_i};
            cnt_q  <= cnt_d;
        end
    end

    assign filt_o = (cnt_q == CW'(FILT));

endmodule

// File: rtl/pwr_seq_ctrl.sv
// Power-rail sequencer: ordered rail bring-up/teardown with fault filtering and latching.
module pwr_seq_ctrl
    import pwr_seq_ctrl_pkg::*;
#(
    parameter int unsigned NCH    = 6,
    parameter int unsigned NG     = 4,
    parameter int unsigned T_RAIL = 100000,
    parameter int unsigned T_CH   = 50000,
    parameter int unsigned FILT   = 16
) (
    input  logic              clk_axi,
    input  logic              rst_axi_n,
    input  logic              pwr_req,
    input  logic [NCH-1:0]    ch_mask,
    input  logic              fault_clr,
    input  logic [NCH-1:0]    ch_flt_raw,
    input  logic [NG-1:0]     glob_flt_raw,
    output logic              en_3v3,
    output logic              en_2v5,
    output logic [NCH-1:0]    vp12_en,
    output logic [2:0]        seq_state,
    output logic [NCH+NG-1:0] flt_latched,
    output logic              seq_busy,
    output logic              pwr_good
);

    localparam int unsigned NF = NCH + NG;
    localparam int unsigned TW = $clog2(max_u(T_RAIL, T_CH) + 1);
    localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [TW-1:0] TRailLd = TW'(T_RAIL - 1);
    localparam logic [TW-1:0] TChLd   = TW'(T_CH - 1);

    seq_state_e     state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [NCH-1:0] mask_q, mask_d;
    logic           en_3v3_q, en_3v3_d;
    logic           en_2v5_q, en_2v5_d;
    logic [NCH-1:0] vp12_q, vp12_d;
    logic [NF-1:0]  flt_q, flt_d;
    logic           busy_q, busy_d;
    logic           good_q, good_d;

    logic [NF-1:0]  filt;
    logic [NCH-1:0] ch_ok, ch_hit;
    logic [NG-1:0]  glob_hit;
    logic [IW-1:0]  hi_idx, adv_idx;
    logic           do_td, do_adv;

    for (genvar g = 0; g < NF; g++) begin : g_filt
        flt_filter #(.FILT(FILT)) u_flt_filter (
            .clk_axi  (clk_axi),
            .rst_axi_n(rst_axi_n),
            .raw_i    ((g < NCH) ? ch_flt_raw[g % NCH] : glob_flt_raw[(g - NCH) % NG]),
            .filt_o   (filt[g])
        );
    end

    assign ch_ok    = mask_q & ~flt_q[NCH-1:0];
    assign ch_hit   = filt[NCH-1:0] & vp12_q;
    assign glob_hit = filt[NF-1:NCH] & {NG{state_q != StOff}};

    always_comb begin
        hi_idx = '0;
        for (int k = 0; k < NCH; k++) begin
            if (vp12_q[k]) hi_idx = IW'(k);
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        idx_d    = idx_q;
        mask_d   = mask_q;
        en_3v3_d = en_3v3_q;
        en_2v5_d = en_2v5_q;
        vp12_d   = vp12_q;
        do_td    = 1'b0;
        do_adv   = 1'b0;
        adv_idx  = '0;

        unique case (state_q)
            StOff: begin
                if (pwr_req && !(|flt_q[NF-1:NCH])) begin
                    state_d  = StUp3v3;
                    en_3v3_d = 1'b1;
                    timer_d  = TRailLd;
                    mask_d   = ch_mask;
                end
            end
            StUp3v3: begin
                if (!pwr_req) begin
                    do_td = 1'b1;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else begin
                    state_d  = StUp2v5;
                    en_2v5_d = 1'b1;
                    timer_d  = TRailLd;
                end
            end
            StUp2v5: begin
                if (!pwr_req) begin
                    do_td = 1'b1;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else begin
                    do_adv = 1'b1;
                end
            end
            StUpCh: begin
                // An ineligible channel falls through here on its first cycle.
                if (!pwr_req) begin
                    do_td = 1'b1;
                end else if (ch_ok[idx_q] && timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else if (idx_q == IW'(NCH - 1)) begin
                    state_d = StOn;
                end else begin
                    do_adv  = 1'b1;
                    adv_idx = idx_q + IW'(1);
                end
            end
            StOn: begin
                if (!pwr_req) do_td = 1'b1;
            end
            StDown: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else begin
                    do_td = 1'b1;
                end
            end
            StFault: begin
                if (fault_clr && !pwr_req && !(|filt[NF-1:NCH])) state_d = StOff;
            end
            default: state_d = StOff;
        endcase

        if (do_adv) begin
            state_d = StUpCh;
            idx_d   = adv_idx;
            if (ch_ok[adv_idx]) begin
                vp12_d[adv_idx] = 1'b1;
                timer_d         = TChLd;
            end
        end

        // One teardown step: highest channel, then 2V5, then 3V3.
        if (do_td) begin
            state_d = StDown;
            if (|vp12_q) begin
                vp12_d[hi_idx] = 1'b0;
                timer_d        = TChLd;
            end else if (en_2v5_q) begin
                en_2v5_d = 1'b0;
                timer_d  = TRailLd;
            end else begin
                en_3v3_d = 1'b0;
                state_d  = StOff;
            end
        end

        vp12_d = vp12_d & ~ch_hit;

        if (|glob_hit) begin
            en_3v3_d = 1'b0;
            en_2v5_d = 1'b0;
            vp12_d   = '0;
            state_d  = StFault;
        end

        // A newly qualified fault beats a same-cycle clear.
        flt_d  = (flt_q & ~({NF{fault_clr}} & ~filt)) | {glob_hit, ch_hit};
        busy_d = (state_d == StUp3v3) || (state_d == StUp2v5) ||
                 (state_d == StUpCh)  || (state_d == StDown);
        good_d = (state_d == StOn) && (flt_d == '0);
    end

    always_ff @(posedge clk_axi or negedge rst_axi_n) begin
        if (!rst_axi_n) begin
            state_q  <= StOff;
            timer_q  <= '0;
            idx_q    <= '0;
            mask_q   <= '0;
            en_3v3_q <= 1'b0;
            en_2v5_q <= 1'b0;
            vp12_q   <= '0;
            flt_q    <= '0;
            busy_q   <= 1'b0;
            good_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            idx_q    <= idx_d;
            mask_q   <= mask_d;
            en_3v3_q <= en_3v3_d;
            en_2v5_q <= en_2v5_d;
            vp12_q   <= vp12_d;
            flt_q    <= flt_d;
            busy_q   <= busy_d;
            good_q   <= good_d;
        end
    end

    assign en_3v3      = en_3v3_q;
    assign en_2v5      = en_2v5_q;
    assign vp12_en     = vp12_q;
    assign seq_state   = state_q;
    assign flt_latched = flt_q;
    assign seq_busy    = busy_q;
    assign pwr_good    = good_q;

endmodule
